// File: rtl/io_gpio_ctrl.sv
// GPIO pad controller: registered pad outputs, synchronized and debounced pad inputs,
// per-pin sticky edge interrupts with write-1-to-clear.
module io_gpio_ctrl #(
  parameter int unsigned PIN_NUM = 8,
  parameter int unsigned DEB_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [PIN_NUM-1:0] out_i,
  input  logic [PIN_NUM-1:0] oe_i,
  input  logic [DEB_W-1:0]   deb_thr_i,
  input  logic [PIN_NUM-1:0] rise_en_i,
  input  logic [PIN_NUM-1:0] fall_en_i,
  input  logic [PIN_NUM-1:0] irq_clr_i,
  output logic [PIN_NUM-1:0] c2p_o,
  output logic [PIN_NUM-1:0] c2p_en_o,
  input  logic [PIN_NUM-1:0] p2c_i,
  output logic [PIN_NUM-1:0] in_o,
  output logic [PIN_NUM-1:0] irq_pend_o,
  output logic               irq_o
);

  logic [PIN_NUM-1:0] c2p_q, c2p_en_q;
  logic [PIN_NUM-1:0] sync1_q, sync2_q;
  logic [PIN_NUM-1:0] filt_q, filt_d, filt_prev_q;
  logic [PIN_NUM-1:0] pend_q, pend_d;
  logic [PIN_NUM-1:0] rise, fall;
  logic [PIN_NUM-1:0][DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] eff_thr;

  // A zero threshold would never let cnt+1 fall short of it; treat it as one cycle.
  assign eff_thr = (deb_thr_i == '0) ? DEB_W'(1) : deb_thr_i;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(PIN_NUM); i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + (DEB_W + 1)'(1)) >= {1'b0, eff_thr}) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // Edges are seen the cycle after filt moves, so pending lands one cycle later still.
  assign rise   = filt_q & ~filt_prev_q;
  assign fall   = ~filt_q & filt_prev_q;
  assign pend_d = (rise & rise_en_i) | (fall & fall_en_i) | (pend_q & ~irq_clr_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c2p_q       <= '0;
      c2p_en_q    <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
    end else begin
      c2p_q       <= out_i;
      c2p_en_q    <= oe_i;
      sync1_q     <= p2c_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
    end
  end

  assign c2p_o      = c2p_q;
  assign c2p_en_o   = c2p_en_q;
  assign in_o       = filt_q;
  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule

// File: tb/tb_io_gpio_ctrl.sv
// Bench for io_gpio_ctrl: directed scenarios then random pad activity, all checked against
// a streak-counting behavioural model of the pin filter and interrupt flags.
module tb_io_gpio_ctrl;
  localparam int unsigned PIN_NUM = 8;
  localparam int unsigned DEB_W   = 8;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b0;
  logic [PIN_NUM-1:0] out_i = '0, oe_i = '0, rise_en_i = '0, fall_en_i = '0, irq_clr_i = '0;
  logic [PIN_NUM-1:0] p2c_i = '0;
  logic [DEB_W-1:0]   deb_thr_i = '0;
  logic [PIN_NUM-1:0] c2p_o, c2p_en_o, in_o, irq_pend_o;
  logic               irq_o;

  int vectors = 0;
  int miscompares = 0;
  bit loopback = 1'b0;

  io_gpio_ctrl #(.PIN_NUM(PIN_NUM), .DEB_W(DEB_W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .out_i      (out_i),
    .oe_i       (oe_i),
    .deb_thr_i  (deb_thr_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .irq_clr_i  (irq_clr_i),
    .c2p_o      (c2p_o),
    .c2p_en_o   (c2p_en_o),
    .p2c_i      (p2c_i),
    .in_o       (in_o),
    .irq_pend_o (irq_pend_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: pad samples pass a two-deep delay line; a pin's level flips once the delayed
  // sample has disagreed with it for eff_thr consecutive cycles.
  logic [PIN_NUM-1:0] m_c2p, m_c2p_en, m_lvl, m_pend, m_rose, m_fell;
  logic [PIN_NUM-1:0] pipe [$];
  int streak [PIN_NUM];

  task automatic model_reset();
    m_c2p = '0; m_c2p_en = '0; m_lvl = '0; m_pend = '0; m_rose = '0; m_fell = '0;
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    for (int i = 0; i < int'(PIN_NUM); i++) streak[i] = 0;
  endtask

  task automatic model_clock();
    logic [PIN_NUM-1:0] seen, rose, fell;
    int eff;
    seen = pipe[0];
    rose = '0;
    fell = '0;
    eff = (deb_thr_i == 0) ? 1 : int'(deb_thr_i);
    m_pend = (m_rose & rise_en_i) | (m_fell & fall_en_i) | (m_pend & ~irq_clr_i);
    for (int i = 0; i < int'(PIN_NUM); i++) begin
      if (seen[i] == m_lvl[i]) begin
        streak[i] = 0;
      end else begin
        streak[i]++;
        if (streak[i] >= eff) begin
          streak[i] = 0;
          m_lvl[i] = seen[i];
          if (seen[i]) rose[i] = 1'b1; else fell[i] = 1'b1;
        end
      end
    end
    m_rose = rose;
    m_fell = fell;
    void'(pipe.pop_front());
    pipe.push_back(p2c_i);
    m_c2p = out_i;
    m_c2p_en = oe_i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("c2p", 32'(c2p_o), 32'(m_c2p));
    chk("c2p_en", 32'(c2p_en_o), 32'(m_c2p_en));
    chk("in", 32'(in_o), 32'(m_lvl));
    chk("irq_pend", 32'(irq_pend_o), 32'(m_pend));
    chk("irq", 32'(irq_o), 32'(|m_pend));
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit after the rise.
  task automatic step();
    @(posedge clk_i);
    if (rst_n_i) model_clock();
    #1;
    check_all();
    @(negedge clk_i);
    if (loopback) p2c_i = c2p_o;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    #1;
    check_all();
    chk("reset_irq", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Held high input with threshold 4 shows up after six cycles, pending one after.
    deb_thr_i = 8'd4;
    rise_en_i[0] = 1'b1;
    p2c_i[0] = 1'b1;
    run(5);
    chk("deb4_early", 32'(in_o[0]), 32'd0);
    run(1);
    chk("deb4_level", 32'(in_o[0]), 32'd1);
    chk("deb4_nopend_yet", 32'(irq_pend_o[0]), 32'd0);
    run(1);
    chk("deb4_pend", 32'(irq_pend_o[0]), 32'd1);
    chk("deb4_irq", 32'(irq_o), 32'd1);
    irq_clr_i[0] = 1'b1;
    run(1);
    irq_clr_i[0] = 1'b0;
    chk("clr0", 32'(irq_pend_o[0]), 32'd0);

    // Three-cycle glitch is swallowed.
    rise_en_i[1] = 1'b1;
    p2c_i[1] = 1'b1;
    run(3);
    p2c_i[1] = 1'b0;
    run(10);
    chk("glitch_in", 32'(in_o[1]), 32'd0);
    chk("glitch_pend", 32'(irq_pend_o[1]), 32'd0);

    // Fall-only enable flags just the falling edge.
    fall_en_i[2] = 1'b1;
    p2c_i[2] = 1'b1;
    run(8);
    chk("fall_after_rise", 32'(irq_pend_o[2]), 32'd0);
    p2c_i[2] = 1'b0;
    run(6);
    chk("fall_before", 32'(irq_pend_o[2]), 32'd0);
    run(1);
    chk("fall_pend", 32'(irq_pend_o[2]), 32'd1);
    irq_clr_i[2] = 1'b1;
    run(1);
    irq_clr_i[2] = 1'b0;
    chk("fall_clr", 32'(irq_pend_o[2]), 32'd0);

    // Clear coinciding with a new set loses.
    rise_en_i[3] = 1'b1;
    p2c_i[3] = 1'b1;
    run(6);
    irq_clr_i[3] = 1'b1;
    run(1);
    irq_clr_i[3] = 1'b0;
    chk("set_over_clr", 32'(irq_pend_o[3]), 32'd1);
    run(1);
    chk("set_over_clr_hold", 32'(irq_pend_o[3]), 32'd1);

    // Output registers and loopback read-back with threshold 0.
    deb_thr_i = 8'd0;
    oe_i = 8'hA5;
    out_i = 8'h3C;
    loopback = 1'b1;
    run(1);
    chk("c2p_en_a5", 32'(c2p_en_o), 32'h0000_00A5);
    chk("c2p_3c", 32'(c2p_o), 32'h0000_003C);
    run(2);
    chk("loop_early", 32'(in_o), 32'h0000_0009);
    run(1);
    chk("loop_in", 32'(in_o), 32'h0000_003C);
    loopback = 1'b0;

    // Reset in the middle of a count.
    p2c_i = '0;
    deb_thr_i = 8'd4;
    out_i = 8'hFF;
    oe_i = 8'hFF;
    run(10);
    rise_en_i[4] = 1'b1;
    p2c_i[4] = 1'b1;
    run(4);
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_c2p", 32'(c2p_o), 32'd0);
    chk("rst_pend", 32'(irq_pend_o), 32'd0);
    @(negedge clk_i);
    run(2);
    rst_n_i = 1'b1;
    run(5);
    chk("rst_fresh_early", 32'(in_o[4]), 32'd0);
    run(1);
    chk("rst_fresh_level", 32'(in_o[4]), 32'd1);
    run(1);
    chk("rst_fresh_pend", 32'(irq_pend_o[4]), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (c % 37 == 0) deb_thr_i = DEB_W'($urandom_range(5));
      if (c % 23 == 0) begin
        rise_en_i = PIN_NUM'($urandom);
        fall_en_i = PIN_NUM'($urandom);
      end
      for (int i = 0; i < int'(PIN_NUM); i++)
        if ($urandom_range(5) == 0) p2c_i[i] = ~p2c_i[i];
      irq_clr_i = PIN_NUM'($urandom) & PIN_NUM'($urandom);
      out_i = PIN_NUM'($urandom);
      oe_i = PIN_NUM'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_gpio_ctrl.md
IO_GPIO_CTRL -- requirements
Module: io_gpio_ctrl

Interface
REQ-001 SHALL have parameter PIN_NUM, default 8, number of GPIO pins served (one tri-state pad per pin).
REQ-002 SHALL have parameter DEB_W, default 8, width of the per-pin debounce counter and threshold.
REQ-003 SHALL have port clk_i  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port out_i  input  PIN_NUM  core output value per pin.
REQ-006 SHALL have port oe_i  input  PIN_NUM  output enable per pin (1 = drive pad).
REQ-007 SHALL have port deb_thr_i  input  DEB_W  debounce threshold in cycles, shared by all pins.
REQ-008 SHALL have port rise_en_i  input  PIN_NUM  rising-edge interrupt enable per pin.
REQ-009 SHALL have port fall_en_i  input  PIN_NUM  falling-edge interrupt enable per pin.
REQ-010 SHALL have port irq_clr_i  input  PIN_NUM  single-cycle write-1-to-clear pulse for pending bits.
REQ-011 SHALL have port c2p_o  output  PIN_NUM  pad output data, to tri pad c2p.
REQ-012 SHALL have port c2p_en_o  output  PIN_NUM  pad output enable, to tri pad c2p_en.
REQ-013 SHALL have port p2c_i  input  PIN_NUM  raw pad input, from tri pad p2c, asynchronous to clk_i.
REQ-014 SHALL have port in_o  output  PIN_NUM  synchronized, debounced pin level.
REQ-015 SHALL have port irq_pend_o  output  PIN_NUM  per-pin sticky edge-pending flags.
REQ-016 SHALL have port irq_o  output  1  OR of all irq_pend_o bits.

Function
REQ-017 SHALL register out_i/oe_i into c2p_o/c2p_en_o: one-cycle latency, no other gating.
REQ-018 SHALL pass each p2c_i bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-019 SHALL sample p2c_i regardless of c2p_en_o (driven pins read back their own pad level).
REQ-020 SHALL keep per pin a filtered level filt and a counter cnt[DEB_W-1:0]; in_o = filt.
REQ-021 SHALL, when sync2 == filt, clear cnt to 0 and hold filt.
REQ-022 SHALL, when sync2 != filt and cnt+1 < eff_thr, increment cnt; eff_thr = max(deb_thr_i, 1).
REQ-023 SHALL, when sync2 != filt and cnt+1 >= eff_thr, load filt <= sync2 and clear cnt.
REQ-024 SHALL therefore give p2c_i -> in_o latency of 2 + eff_thr cycles for a stable input; deb_thr_i = 0 behaves as 1.
REQ-025 SHALL discard any glitch on sync2 shorter than eff_thr cycles (cnt resets, filt unchanged).
REQ-026 SHALL never overflow cnt: saturation is impossible as cnt < eff_thr <= 2^DEB_W-1.
REQ-027 SHALL apply a deb_thr_i change immediately; if cnt+1 already >= new eff_thr, filt updates that cycle.
REQ-028 SHALL detect a rising edge as filt 0->1 and a falling edge as filt 1->0, evaluated on the cycle filt changes.
REQ-029 SHALL set irq_pend_o[i] on the cycle after a detected edge whose type is enabled in rise_en_i[i]/fall_en_i[i].
REQ-030 SHALL hold irq_pend_o[i] until irq_clr_i[i] = 1; clearing takes effect the next cycle.
REQ-031 SHALL give set priority over clear when set and clear hit the same pin in the same cycle.
REQ-032 SHALL not retroactively set pending when an edge enable is raised after the edge occurred.
REQ-033 SHALL drive irq_o combinationally as the OR reduction of irq_pend_o.

Reset
REQ-034 SHALL, on rst_n_i low, asynchronously force c2p_o = 0, c2p_en_o = 0 (all pads input), sync1 = sync2 = 0, filt = 0, cnt = 0, irq_pend_o = 0, irq_o = 0.
REQ-035 SHALL abort any in-progress debounce count on reset; no edge is flagged for the reset transition itself.
REQ-036 SHALL, after reset release with a pad held high, report a rising edge on in_o after 2 + eff_thr cycles (flagged only if rise_en set).

Verification
REQ-037 SHALL cover: deb_thr_i = 4, p2c_i[0] 0->1 held -> in_o[0] = 1 exactly 6 cycles later; with rise_en_i[0] = 1, irq_pend_o[0] and irq_o = 1 one cycle after.
REQ-038 SHALL cover: deb_thr_i = 4, 3-cycle high pulse on p2c_i[1] -> in_o[1] stays 0, irq_pend_o[1] stays 0.
REQ-039 SHALL cover: fall_en_i[2] = 1, rise_en_i[2] = 0, pin toggles 0->1->0 -> only one pending set, after the fall; irq_clr_i[2] pulse -> irq_pend_o[2] = 0 next cycle.
REQ-040 SHALL cover: irq_clr_i[3] asserted in the same cycle a new enabled edge sets pin 3 -> irq_pend_o[3] remains 1.
REQ-041 SHALL cover: oe_i = 8'hA5, out_i = 8'h3C -> c2p_en_o = 8'hA5, c2p_o = 8'h3C one cycle later; with p2c_i looped from c2p_o, deb_thr_i = 0 -> in_o = 8'h3C 3 cycles after c2p_o.
REQ-042 SHALL cover: rst_n_i asserted mid-count (cnt = 2 of 4) -> all outputs 0 immediately; after release, fresh debounce from cnt = 0.
